// File: rtl/sram_block_ctrl_if.sv
// Request/response bundle between a datapath core (master) and sram_block_ctrl (slave).
interface sram_block_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [15:0]  req_addr;
  logic [3:0]   req_len;
  logic [127:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_last;
  logic         rsp_err;
  logic [127:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata,
    input  req_ready, rsp_valid, rsp_last, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata,
    output req_ready, rsp_valid, rsp_last, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/sram_block_ctrl.sv
// Initiator-side SRAM controller: single-block writes, 1..16 block burst reads, registered pin drive.
// Optional alignment rejection of requests is enabled by defining SRAM_CTRL_ALIGN_CHECK_EN.
module sram_block_ctrl #(
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  sram_block_ctrl_if.slave bus,
  output logic             sram_read_enable,
  output logic             sram_write_enable,
  output logic [15:0]      sram_address,
  output logic [127:0]     sram_write_data,
  input  logic [127:0]     sram_read_data
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [7:0] RD_LAST = 8'(READ_WAIT - 1);
  localparam logic [7:0] WR_LAST = 8'(WRITE_WAIT - 1);

  state_t       state_r, state_next_s;
  logic [7:0]   cnt_r, cnt_next_s;
  logic [3:0]   beats_r, beats_next_s;
  logic [15:0]  addr_r, addr_next_s;
  logic [127:0] wdata_r, wdata_next_s;
  logic [127:0] rdata_r, rdata_next_s;
  logic         rd_en_r, rd_en_next_s;
  logic         wr_en_r, wr_en_next_s;
  logic         ready_r, ready_next_s;
  logic         valid_r, valid_next_s;
  logic         last_r, last_next_s;
  logic         misalign_s;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
  logic         err_r, err_next_s;

  assign misalign_s  = (bus.req_addr[3:0] != 4'h0);
  assign bus.rsp_err = err_r;
`else
  assign misalign_s  = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready     = ready_r;
  assign bus.rsp_valid     = valid_r;
  assign bus.rsp_last      = last_r;
  assign bus.rsp_rdata     = rdata_r;
  assign sram_read_enable  = rd_en_r;
  assign sram_write_enable = wr_en_r;
  assign sram_address      = addr_r;
  assign sram_write_data   = wdata_r;

  // Next-state and next-output decode; every pin value is computed here and registered below.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    beats_next_s = beats_r;
    addr_next_s  = addr_r;
    wdata_next_s = wdata_r;
    rdata_next_s = rdata_r;
    rd_en_next_s = 1'b0;
    wr_en_next_s = 1'b0;
    valid_next_s = 1'b0;
    last_next_s  = 1'b0;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
    err_next_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          cnt_next_s = 8'd0;
          if (misalign_s) begin
            state_next_s = ST_ERR;
          end else begin
            addr_next_s  = bus.req_addr;
            beats_next_s = bus.req_len;
            wdata_next_s = bus.req_wdata;
            if (bus.req_write) begin
              state_next_s = ST_WR;
              wr_en_next_s = 1'b1;
            end else begin
              state_next_s = ST_RD;
              rd_en_next_s = 1'b1;
            end
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RD: begin
        rd_en_next_s = 1'b1;
        if (cnt_r == RD_LAST) begin
          rdata_next_s = sram_read_data;
          valid_next_s = 1'b1;
          cnt_next_s   = 8'd0;
          // Keep read_enable asserted across beats; only the address steps (wrapping at 64 KiB).
          if (beats_r != 4'd0) begin
            beats_next_s = beats_r - 4'd1;
            addr_next_s  = addr_r + 16'd16;
          end else begin
            last_next_s  = 1'b1;
            rd_en_next_s = 1'b0;
            state_next_s = ST_IDLE;
          end
        end else begin
          cnt_next_s = cnt_r + 8'd1;
        end
      end
      ST_WR: begin
        wr_en_next_s = 1'b1;
        if (cnt_r == WR_LAST) begin
          valid_next_s = 1'b1;
          last_next_s  = 1'b1;
          wr_en_next_s = 1'b0;
          state_next_s = ST_IDLE;
        end else begin
          cnt_next_s = cnt_r + 8'd1;
        end
      end
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
      ST_ERR: begin
        valid_next_s = 1'b1;
        last_next_s  = 1'b1;
        err_next_s   = 1'b1;
        state_next_s = ST_IDLE;
      end
`endif
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    ready_next_s = (state_next_s == ST_IDLE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      beats_r <= 4'd0;
      addr_r  <= 16'd0;
      wdata_r <= 128'd0;
      rdata_r <= 128'd0;
      rd_en_r <= 1'b0;
      wr_en_r <= 1'b0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
      err_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      beats_r <= beats_next_s;
      addr_r  <= addr_next_s;
      wdata_r <= wdata_next_s;
      rdata_r <= rdata_next_s;
      rd_en_r <= rd_en_next_s;
      wr_en_r <= wr_en_next_s;
      ready_r <= ready_next_s;
      valid_r <= valid_next_s;
      last_r  <= last_next_s;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
      err_r   <= err_next_s;
`endif
    end
  end
endmodule

// File: tb/tb_sram_block_ctrl.sv
// Self-checking bench for sram_block_ctrl: directed plus random requests against a timing/memory model.
// Honours SRAM_CTRL_ALIGN_CHECK_EN when the design is built with it.
module tb_sram_block_ctrl;
  localparam int RW = 1;
  localparam int WW = 2;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  typedef struct packed {
    int           cyc;
    logic [15:0]  addr;
    logic [127:0] data;
    logic         last;
    logic         err;
  } ev_t;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         sram_read_enable, sram_write_enable;
  logic [15:0]  sram_address;
  logic [127:0] sram_write_data, sram_read_data;
  logic [127:0] sram_mem [0:65535];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_done = 0;
  int both_en_cnt = 0;
  logic [127:0] last_rdata = 128'd0;
  logic [127:0] ref_mem [logic [15:0]];
  ev_t obs_rd[$], obs_wr[$], obs_rsp[$];
  ev_t exp_rd[$], exp_wr[$], exp_rsp[$];

  sram_block_ctrl_if bus ();

  sram_block_ctrl #(.READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .bus              (bus),
    .sram_read_enable (sram_read_enable),
    .sram_write_enable(sram_write_enable),
    .sram_address     (sram_address),
    .sram_write_data  (sram_write_data),
    .sram_read_data   (sram_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] fill(input logic [15:0] a);
    return {4{a, a ^ 16'hC3A5}};
  endfunction

  function automatic logic [127:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return fill(a);
  endfunction

  // Behavioural SRAM: asynchronous read, write on the clock edge.
  initial begin
    for (int i = 0; i < 65536; i++) sram_mem[i] = fill(16'(i));
  end
  assign sram_read_data = sram_mem[sram_address];
  always @(posedge clk) if (sram_write_enable) sram_mem[sram_address] <= sram_write_data;

  // Observe pins mid-cycle and log every enable cycle and response pulse.
  always @(negedge clk) begin
    ev_t ev;
    if (n_rst) begin
      if (sram_read_enable && sram_write_enable) both_en_cnt++;
      if (sram_read_enable) begin
        ev = '{cyc: cyc, addr: sram_address, data: 128'd0, last: 1'b0, err: 1'b0};
        obs_rd.push_back(ev);
      end
      if (sram_write_enable) begin
        ev = '{cyc: cyc, addr: sram_address, data: sram_write_data, last: 1'b0, err: 1'b0};
        obs_wr.push_back(ev);
      end
      if (bus.rsp_valid) begin
        ev = '{cyc: cyc, addr: 16'd0, data: bus.rsp_rdata, last: bus.rsp_last, err: bus.rsp_err};
        obs_rsp.push_back(ev);
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input ev_t o[$], input ev_t e[$]);
    check({tag, ".count"}, 128'(o.size()), 128'(e.size()));
    for (int i = 0; i < e.size() && i < o.size(); i++) begin
      check($sformatf("%s[%0d].cyc", tag, i), 128'(o[i].cyc), 128'(e[i].cyc));
      check($sformatf("%s[%0d].addr", tag, i), 128'(o[i].addr), 128'(e[i].addr));
      check($sformatf("%s[%0d].data", tag, i), o[i].data, e[i].data);
      check($sformatf("%s[%0d].last", tag, i), 128'(o[i].last), 128'(e[i].last));
      check($sformatf("%s[%0d].err", tag, i), 128'(o[i].err), 128'(e[i].err));
    end
  endtask

  // Drive one request, hold it until accepted, then predict every pin event it should cause.
  task automatic issue(input bit wr, input logic [15:0] a, input logic [3:0] len, input logic [127:0] wd);
    int c, e0, exp_e0;
    bit accepted;
    logic [15:0] ba;
    logic [127:0] d;
    ev_t ev;
    c = cyc;
    exp_e0 = ((c > exp_done) ? c : exp_done) + 1;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_len   = len;
    bus.req_wdata = wd;
    accepted = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      if (bus.req_ready) accepted = 1'b1;
      else @(negedge clk);
    end
    check("accept_timeout", 128'(accepted), 128'd1);
    e0 = cyc + 1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("accept_cyc", 128'(e0), 128'(exp_e0));
    if (ALIGN_CHK && a[3:0] != 4'h0) begin
      ev = '{cyc: e0 + 1, addr: 16'd0, data: last_rdata, last: 1'b1, err: 1'b1};
      exp_rsp.push_back(ev);
      exp_done = e0 + 1;
    end else if (wr) begin
      for (int j = 0; j < WW; j++) begin
        ev = '{cyc: e0 + j, addr: a, data: wd, last: 1'b0, err: 1'b0};
        exp_wr.push_back(ev);
      end
      ev = '{cyc: e0 + WW, addr: 16'd0, data: last_rdata, last: 1'b1, err: 1'b0};
      exp_rsp.push_back(ev);
      ref_mem[a] = wd;
      exp_done = e0 + WW;
    end else begin
      for (int k = 0; k <= int'(len); k++) begin
        ba = a + 16'(16 * k);
        for (int j = 0; j < RW; j++) begin
          ev = '{cyc: e0 + k * RW + j, addr: ba, data: 128'd0, last: 1'b0, err: 1'b0};
          exp_rd.push_back(ev);
        end
        d = ref_read(ba);
        last_rdata = d;
        ev = '{cyc: e0 + (k + 1) * RW, addr: 16'd0, data: d, last: (k == int'(len)), err: 1'b0};
        exp_rsp.push_back(ev);
      end
      exp_done = e0 + (int'(len) + 1) * RW;
    end
  endtask

  initial begin
    logic [15:0] a;
    n_rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'd0;
    bus.req_len   = 4'd0;
    bus.req_wdata = 128'd0;
    repeat (3) @(negedge clk);
    check("rst.req_ready", 128'(bus.req_ready), 128'd1);
    check("rst.rsp_valid", 128'(bus.rsp_valid), 128'd0);
    check("rst.rsp_last", 128'(bus.rsp_last), 128'd0);
    check("rst.rsp_err", 128'(bus.rsp_err), 128'd0);
    check("rst.rsp_rdata", bus.rsp_rdata, 128'd0);
    check("rst.rd_en", 128'(sram_read_enable), 128'd0);
    check("rst.wr_en", 128'(sram_write_enable), 128'd0);
    check("rst.address", 128'(sram_address), 128'd0);
    check("rst.wdata", sram_write_data, 128'd0);
    n_rst = 1'b1;
    @(negedge clk);

    issue(1'b1, 16'h0010, 4'd0, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    issue(1'b0, 16'h0010, 4'd0, 128'd0);
    issue(1'b0, 16'hFFE0, 4'd3, 128'd0);
    issue(1'b0, 16'h0013, 4'd0, 128'd0);
    issue(1'b1, 16'hFFF0, 4'd0, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    issue(1'b0, 16'hFFF0, 4'd1, 128'd0);
    for (int n = 0; n < 24; n++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, 15) << 4);
      else if ($urandom_range(0, 3) != 0) a[3:0] = 4'h0;
      issue(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
            {$urandom, $urandom, $urandom, $urandom});
    end
    for (int i = 0; i < 2000 && cyc <= exp_done + 2; i++) @(negedge clk);

    cmp_q("rd", obs_rd, exp_rd);
    cmp_q("wr", obs_wr, exp_wr);
    cmp_q("rsp", obs_rsp, exp_rsp);
    check("enable_overlap", 128'(both_en_cnt), 128'd0);

    // Abort a long burst with an asynchronous reset between clock edges.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0200;
    bus.req_len   = 4'd15;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midrd.rd_en_before", 128'(sram_read_enable), 128'd1);
    #2 n_rst = 1'b0;
    #1;
    check("midrd.rd_en", 128'(sram_read_enable), 128'd0);
    check("midrd.wr_en", 128'(sram_write_enable), 128'd0);
    check("midrd.rsp_valid", 128'(bus.rsp_valid), 128'd0);
    check("midrd.req_ready", 128'(bus.req_ready), 128'd1);
    check("midrd.address", 128'(sram_address), 128'd0);
    check("midrd.rsp_rdata", bus.rsp_rdata, 128'd0);
    obs_rd.delete();
    obs_wr.delete();
    obs_rsp.delete();
    @(negedge clk);
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    check("midrd.no_rsp", 128'(obs_rsp.size()), 128'd0);
    check("midrd.no_rd", 128'(obs_rd.size()), 128'd0);
    check("midrd.ready_after", 128'(bus.req_ready), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
